// File: rtl/root_feeder_pkg.sv
// Shared types and defaults for the root evaluation feeder.
package root_feeder_pkg;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      ARG0,
      ARG1,
      START,
      WAIT,
      PUSH
   } state_t;

endpackage

// File: rtl/root_feeder_fifo.sv
// Circular result FIFO; OUT side reads the head straight from storage.
module root_feeder_fifo #(
   parameter int unsigned W          = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         WR,
   input  logic [W-1:0] WDATA,
   output logic         FULL,
   input  logic         RD_EN,
   output logic [W-1:0] RDATA,
   output logic         EMPTY
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   // Extra pointer MSB separates full from empty when the indices match.
   assign EMPTY = (wr_ptr == rd_ptr);
   assign FULL  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign RDATA = mem[rd_ptr[AW-1:0]];

   assign do_rd = RD_EN && !EMPTY;
   assign do_wr = WR && (!FULL || do_rd);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '{default: '0};
      end else begin
         if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= WDATA;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/root_feeder.sv
// Packs argument word pairs into IN0/IN1, starts the root, collects RES into
// a result FIFO and aborts jobs whose root never reports ready.
module root_feeder
   import root_feeder_pkg::*;
#(
   parameter int unsigned W          = DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   input  logic [W-1:0] IN_DATA,
   output logic         IN_READY,
   output logic         ST,
   output logic [W-1:0] IN0,
   output logic [W-1:0] IN1,
   input  logic         RD,
   input  logic [W-1:0] RES,
   output logic         OUT_VALID,
   output logic [W-1:0] OUT_DATA,
   input  logic         OUT_READY,
   output logic         BUSY,
   output logic         ERR,
   input  logic         CLR_ERR
);

   localparam int unsigned WDW = $clog2(TIMEOUT);

   state_t         state;
   logic [WDW-1:0] wdog;
   logic [W-1:0]   res_q;
   logic           fifo_full;
   logic           fifo_empty;
   logic           pop;
   logic           push;

   assign OUT_VALID = !fifo_empty;
   assign pop       = OUT_VALID && OUT_READY;
   // A pop in the same cycle makes room even when the FIFO reads full.
   assign push      = (state == PUSH) && (!fifo_full || pop);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ARG0;
         IN0      <= '0;
         IN1      <= '0;
         ST       <= 1'b0;
         IN_READY <= 1'b1;
         BUSY     <= 1'b0;
         ERR      <= 1'b0;
         wdog     <= '0;
         res_q    <= '0;
      end else begin
         ST <= 1'b0;
         if (CLR_ERR) begin
            ERR <= 1'b0;
         end
         case (state)
            ARG0: begin
               if (IN_VALID) begin
                  IN0   <= IN_DATA;
                  BUSY  <= 1'b1;
                  state <= ARG1;
               end
            end
            ARG1: begin
               if (IN_VALID) begin
                  IN1      <= IN_DATA;
                  ST       <= 1'b1;
                  IN_READY <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               wdog  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // RD beats the watchdog when both land in the same cycle.
               if (RD) begin
                  res_q <= RES;
                  state <= PUSH;
               end else if (wdog == WDW'(TIMEOUT - 1)) begin
                  ERR      <= 1'b1;
                  IN_READY <= 1'b1;
                  BUSY     <= 1'b0;
                  state    <= ARG0;
               end else begin
                  wdog <= wdog + WDW'(1);
               end
            end
            PUSH: begin
               if (push) begin
                  IN_READY <= 1'b1;
                  BUSY     <= 1'b0;
                  state    <= ARG0;
               end
            end
            default: begin
               IN_READY <= 1'b1;
               BUSY     <= 1'b0;
               state    <= ARG0;
            end
         endcase
      end
   end

   root_feeder_fifo #(
      .W          (W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .WR    (push),
      .WDATA (res_q),
      .FULL  (fifo_full),
      .RD_EN (pop),
      .RDATA (OUT_DATA),
      .EMPTY (fifo_empty)
   );

endmodule

// File: tb/tb_root_feeder.sv
// Directed bench for root_feeder with a root stub (RES = IN0 + IN1) and a
// job-level scoreboard checked every cycle.
module tb_root_feeder;

   localparam int unsigned W = 16;

   logic         CLK = 1'b0;
   logic         RST;
   logic         IN_VALID;
   logic [W-1:0] IN_DATA;
   logic         IN_READY;
   logic         ST;
   logic [W-1:0] IN0;
   logic [W-1:0] IN1;
   logic         RD;
   logic [W-1:0] RES;
   logic         OUT_VALID;
   logic [W-1:0] OUT_DATA;
   logic         OUT_READY;
   logic         BUSY;
   logic         ERR;
   logic         CLR_ERR;

   int checks   = 0;
   int failures = 0;

   // Model: pending argument pairs, expected results in order, current job.
   logic [2*W-1:0] arg_q [$];
   logic [W-1:0]   sb_q [$];
   logic [W-1:0]   cur_in0  = '0;
   logic [W-1:0]   cur_in1  = '0;
   logic           prev_st  = 1'b0;
   int             st_count = 0;

   // Root stub controls.
   int           rd_delay = 0;
   logic         rd_hold  = 1'b0;
   logic [W-1:0] hold_res = '0;
   int           stub_cnt = 0;
   logic         stub_armed = 1'b0;
   logic [W-1:0] stub_res = '0;

   root_feeder #(
      .W          (16),
      .FIFO_DEPTH (4),
      .TIMEOUT    (8)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_DATA   (IN_DATA),
      .IN_READY  (IN_READY),
      .ST        (ST),
      .IN0       (IN0),
      .IN1       (IN1),
      .RD        (RD),
      .RES       (RES),
      .OUT_VALID (OUT_VALID),
      .OUT_DATA  (OUT_DATA),
      .OUT_READY (OUT_READY),
      .BUSY      (BUSY),
      .ERR       (ERR),
      .CLR_ERR   (CLR_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] d);
      int n = 0;
      tick();
      IN_VALID = 1'b1;
      IN_DATA  = d;
      @(negedge CLK);
      while (!IN_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("send_ready_seen", 32'(IN_READY), 32'd1);
      tick();
      IN_VALID = 1'b0;
   endtask

   task automatic send_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
      arg_q.push_back({a, b});
      if (expect_res) sb_q.push_back(W'(a + b));
      send_word(a);
      send_word(b);
   endtask

   task automatic drain(input int cycles);
      tick();
      OUT_READY = 1'b1;
      repeat (cycles) tick();
      OUT_READY = 1'b0;
   endtask

   // Root stub: after ST, raise RD for one cycle rd_delay cycles later.
   initial begin
      RD  = 1'b0;
      RES = '0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            stub_armed = 1'b0;
         end else if (ST && rd_delay > 0) begin
            stub_armed = 1'b1;
            stub_cnt   = rd_delay;
            stub_res   = W'(IN0 + IN1);
         end
         tick();
         if (rd_hold) begin
            RD  = 1'b1;
            RES = hold_res;
         end else begin
            RD = 1'b0;
         end
         if (stub_armed && !RST) begin
            if (stub_cnt == 1) begin
               RD         = 1'b1;
               RES        = stub_res;
               stub_armed = 1'b0;
            end else begin
               stub_cnt--;
            end
         end
      end
   end

   // Per-cycle compare against the job-level model.
   always @(negedge CLK) begin
      if (RST) begin
         prev_st = 1'b0;
      end else begin
         if (ST) begin
            st_count++;
            check("st_one_cycle", 32'(prev_st), 32'd0);
            check("st_has_job", 32'(arg_q.size() != 0), 32'd1);
            if (arg_q.size() != 0) {cur_in0, cur_in1} = arg_q.pop_front();
         end
         if (BUSY && !IN_READY) begin
            check("in0_held", 32'(IN0), 32'(cur_in0));
            check("in1_held", 32'(IN1), 32'(cur_in1));
         end
         if (OUT_VALID && OUT_READY) begin
            check("pop_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("pop_data", 32'(OUT_DATA), 32'(sb_q.pop_front()));
         end
         prev_st = ST;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st0;
      int n;
      RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0; CLR_ERR = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_st", 32'(ST), 32'd0);
      check("rst_in_ready", 32'(IN_READY), 32'd1);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      check("rst_out_data", 32'(OUT_DATA), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_in0", 32'(IN0), 32'd0);
      check("rst_in1", 32'(IN1), 32'd0);
      RST = 1'b0;

      // Single job, RD three cycles after ST.
      st0 = st_count;
      rd_delay = 3;
      send_job(16'h0003, 16'h0005, 1'b1);
      @(negedge CLK);
      check("t1_st", 32'(ST), 32'd1);
      check("t1_in0", 32'(IN0), 32'h3);
      check("t1_in1", 32'(IN1), 32'h5);
      check("t1_in_ready_start", 32'(IN_READY), 32'd0);
      @(negedge CLK);
      check("t1_st_low", 32'(ST), 32'd0);
      repeat (3) @(negedge CLK);
      check("t1_valid_before", 32'(OUT_VALID), 32'd0);
      check("t1_busy_push", 32'(BUSY), 32'd1);
      @(negedge CLK);
      check("t1_valid", 32'(OUT_VALID), 32'd1);
      check("t1_data", 32'(OUT_DATA), 32'h8);
      check("t1_err", 32'(ERR), 32'd0);
      check("t1_busy_idle", 32'(BUSY), 32'd0);
      check("t1_st_count", 32'(st_count - st0), 32'd1);
      drain(1);
      @(negedge CLK);
      check("t1_drained", 32'(OUT_VALID), 32'd0);

      // Back-to-back jobs into a stalled consumer.
      rd_delay = 1;
      for (int i = 0; i < 5; i++) send_job(W'(16'h0100 + i), W'(16'h0200 + i), 1'b1);
      repeat (8) @(negedge CLK);
      check("t2_busy_stall", 32'(BUSY), 32'd1);
      check("t2_in_ready_stall", 32'(IN_READY), 32'd0);
      check("t2_valid", 32'(OUT_VALID), 32'd1);
      check("t2_head", 32'(OUT_DATA), 32'h0300);
      tick();
      OUT_READY = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check("t2_all_drained", 32'(sb_q.size()), 32'd0);
      @(negedge CLK);
      check("t2_valid_empty", 32'(OUT_VALID), 32'd0);
      check("t2_busy_idle", 32'(BUSY), 32'd0);
      tick();
      OUT_READY = 1'b0;

      // Timeout with RD held low.
      rd_delay = 0;
      send_job(16'h0001, 16'h0002, 1'b0);
      repeat (9) @(negedge CLK);
      check("t3_err_before", 32'(ERR), 32'd0);
      check("t3_busy_wait", 32'(BUSY), 32'd1);
      @(negedge CLK);
      check("t3_err_set", 32'(ERR), 32'd1);
      check("t3_busy_idle", 32'(BUSY), 32'd0);
      check("t3_in_ready", 32'(IN_READY), 32'd1);
      check("t3_no_write", 32'(OUT_VALID), 32'd0);
      repeat (2) @(negedge CLK);
      check("t3_err_sticky", 32'(ERR), 32'd1);
      tick();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      @(negedge CLK);
      check("t3_err_clr", 32'(ERR), 32'd0);

      // Timeout coinciding with CLR_ERR: set wins.
      send_job(16'h0004, 16'h0004, 1'b0);
      repeat (8) @(negedge CLK);
      tick();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      @(negedge CLK);
      check("t3b_set_wins", 32'(ERR), 32'd1);
      tick();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      @(negedge CLK);
      check("t3b_err_clr", 32'(ERR), 32'd0);

      // RD on the last watchdog cycle.
      rd_delay = 8;
      send_job(16'h0007, 16'h0009, 1'b1);
      repeat (9) @(negedge CLK);
      check("t4_busy_last", 32'(BUSY), 32'd1);
      @(negedge CLK);
      check("t4_push_not_yet", 32'(OUT_VALID), 32'd0);
      @(negedge CLK);
      check("t4_valid", 32'(OUT_VALID), 32'd1);
      check("t4_data", 32'(OUT_DATA), 32'h0010);
      check("t4_err", 32'(ERR), 32'd0);
      drain(1);
      @(negedge CLK);
      check("t4_drained", 32'(OUT_VALID), 32'd0);

      // RD held high through START: one capture only.
      rd_delay = 0;
      hold_res = 16'h0030;
      rd_hold  = 1'b1;
      tick();
      tick();
      send_job(16'h0010, 16'h0020, 1'b1);
      @(negedge CLK);
      check("t5_st", 32'(ST), 32'd1);
      check("t5_rd_high", 32'(RD), 32'd1);
      repeat (3) @(negedge CLK);
      check("t5_valid", 32'(OUT_VALID), 32'd1);
      check("t5_data", 32'(OUT_DATA), 32'h0030);
      rd_hold = 1'b0;
      drain(3);
      @(negedge CLK);
      check("t5_single_entry", 32'(OUT_VALID), 32'd0);
      check("t5_busy", 32'(BUSY), 32'd0);

      // Reset in WAIT with two queued results.
      rd_delay = 1;
      send_job(16'h000a, 16'h000b, 1'b1);
      send_job(16'h000c, 16'h000d, 1'b1);
      repeat (4) @(negedge CLK);
      check("t6_queued", 32'(OUT_VALID), 32'd1);
      rd_delay = 0;
      send_job(16'h000e, 16'h000f, 1'b0);
      repeat (3) @(negedge CLK);
      check("t6_in_wait", 32'(BUSY), 32'd1);
      #1;
      RST = 1'b1;
      #1;
      check("t6_st", 32'(ST), 32'd0);
      check("t6_out_valid", 32'(OUT_VALID), 32'd0);
      check("t6_busy", 32'(BUSY), 32'd0);
      check("t6_in_ready", 32'(IN_READY), 32'd1);
      check("t6_out_data", 32'(OUT_DATA), 32'd0);
      check("t6_in0", 32'(IN0), 32'd0);
      sb_q.delete();
      arg_q.delete();
      tick();
      RST = 1'b0;
      rd_delay = 2;
      send_job(16'h0021, 16'h0022, 1'b1);
      repeat (6) @(negedge CLK);
      check("t6_fresh_valid", 32'(OUT_VALID), 32'd1);
      check("t6_fresh_data", 32'(OUT_DATA), 32'h0043);
      check("t6_fresh_err", 32'(ERR), 32'd0);
      drain(1);
      @(negedge CLK);
      check("t6_fresh_drained", 32'(OUT_VALID), 32'd0);

      check("end_sb_empty", 32'(sb_q.size()), 32'd0);
      check("end_args_empty", 32'(arg_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
